// File: rtl/updown_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and its surroundings: the
// board-level start/stop/bounds, the counter feedback and the counter
// control outputs. The controller uses the slave view and its driver uses
// the master view.
interface updown_sweep_ctrl_if;
    logic       start;
    logic       stop;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] q;
    logic       up;
    logic       en;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] pass_cnt;

    modport master (
        output start, stop, lo, hi, q,
        input  up, en, cnt_clr, busy, done, err, pass_cnt
    );

    modport slave (
        input  start, stop, lo, hi, q,
        output up, en, cnt_clr, busy, done, err, pass_cnt
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller for a 4-bit up/down counter. It clears the counter,
// seeks up to lo, then bounces between lo and hi, dwelling DWELL cycles at
// each bound, for PASSES round trips (PASSES = 0 runs until stopped).
// The loop is closed on the fed-back counter value q. Each transition is
// taken on the edge where the counter is one step short of the target, so
// the counter lands exactly on the bound on the edge the FSM changes state.
module updown_sweep_ctrl #(
    parameter int unsigned DWELL  = 3,
    parameter int unsigned PASSES = 2
) (
    input  logic              clk,
    input  logic              clr,
    updown_sweep_ctrl_if.slave bus
);

    localparam int unsigned   DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [3:0]    PASS_TGT   = 4'(PASSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SEEK,
        S_RISE,
        S_TOP,
        S_FALL,
        S_BOTTOM,
        S_FINISH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] dwell_cnt;
    logic [3:0]    pass_cnt_r;
    logic          err_r;

    logic          lo_lt_hi;
    logic          dwell_last;
    logic          pass_last;
    logic          stop_hit;
    logic [3:0]    lo_m1;
    logic [3:0]    lo_p1;
    logic [3:0]    hi_m1;
    logic [3:0]    pass_inc;

    logic          up_c;
    logic          en_c;
    logic          cnt_clr_c;
    logic          done_c;

    assign lo_lt_hi   = (bus.lo < bus.hi);
    assign lo_m1      = bus.lo - 4'd1;
    assign lo_p1      = bus.lo + 4'd1;
    assign hi_m1      = bus.hi - 4'd1;
    assign dwell_last = (dwell_cnt == DWELL_LAST);
    // pass_cnt wraps 15 -> 0 naturally when running endlessly.
    assign pass_inc   = pass_cnt_r + 4'd1;
    assign pass_last  = (PASSES != 0) && (pass_inc == PASS_TGT);
    // stop is ignored in IDLE (start wins) and in FINISH (done always pulses).
    assign stop_hit   = bus.stop && (state != S_IDLE) && (state != S_FINISH);

    // State register; reset lands in IDLE without touching the counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore decode of the counter controls.
    always_comb begin
        state_nxt = state;
        up_c      = 1'b1;
        en_c      = 1'b0;
        cnt_clr_c = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && lo_lt_hi) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_clr_c = 1'b1;
                state_nxt = (bus.lo == 4'd0) ? S_RISE : S_SEEK;
            end
            S_SEEK: begin
                en_c = 1'b1;
                if (bus.q == lo_m1) state_nxt = S_RISE;
            end
            S_RISE: begin
                en_c = 1'b1;
                if (bus.q == hi_m1) state_nxt = S_TOP;
            end
            S_TOP: begin
                up_c = 1'b0;
                if (dwell_last) state_nxt = S_FALL;
            end
            S_FALL: begin
                up_c = 1'b0;
                en_c = 1'b1;
                if (bus.q == lo_p1) state_nxt = S_BOTTOM;
            end
            S_BOTTOM: begin
                if (dwell_last) state_nxt = pass_last ? S_FINISH : S_RISE;
            end
            S_FINISH: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (stop_hit) state_nxt = S_IDLE;
    end

    // Dwell counter: zero on every state change, counts while parked at a bound.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dwell_cnt <= '0;
        end else if (state_nxt != state) begin
            dwell_cnt <= '0;
        end else if ((state == S_TOP) || (state == S_BOTTOM)) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Round-trip counter: cleared by an accepted start, bumped on the last
    // BOTTOM cycle unless that cycle is being aborted.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pass_cnt_r <= 4'd0;
        end else if ((state == S_IDLE) && bus.start && lo_lt_hi) begin
            pass_cnt_r <= 4'd0;
        end else if ((state == S_BOTTOM) && dwell_last && !stop_hit) begin
            pass_cnt_r <= pass_inc;
        end
    end

    // Registered one-cycle error pulse for a start with illegal bounds.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state == S_IDLE) && bus.start && !lo_lt_hi;
        end
    end

    assign bus.up       = up_c;
    assign bus.en       = en_c;
    assign bus.cnt_clr  = cnt_clr_c;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_c;
    assign bus.err      = err_r;
    assign bus.pass_cnt = pass_cnt_r;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl. Three controllers with different DWELL /
// PASSES settings each drive a behavioural 4-bit up/down counter whose
// value is fed back as q. Stimulus pushes hand-computed per-cycle expected
// outputs into a per-instance queue; a monitor on the falling edge pops
// one entry whenever a controller shows any activity and compares.
module tb_updown_sweep_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    updown_sweep_ctrl_if if0 ();
    updown_sweep_ctrl_if if1 ();
    updown_sweep_ctrl_if if2 ();

    updown_sweep_ctrl #(.DWELL(2), .PASSES(1)) u0 (.clk(clk), .clr(clr), .bus(if0));
    updown_sweep_ctrl #(.DWELL(3), .PASSES(2)) u1 (.clk(clk), .clr(clr), .bus(if1));
    updown_sweep_ctrl #(.DWELL(1), .PASSES(0)) u2 (.clk(clk), .clr(clr), .bus(if2));

    // Counter models: synchronous clear, otherwise step when enabled.
    logic [3:0] cq0 = 4'd0;
    logic [3:0] cq1 = 4'd0;
    logic [3:0] cq2 = 4'd0;
    assign if0.q = cq0;
    assign if1.q = cq1;
    assign if2.q = cq2;

    always @(posedge clk) begin
        if (if0.cnt_clr) cq0 <= 4'd0;
        else if (if0.en) cq0 <= if0.up ? cq0 + 4'd1 : cq0 - 4'd1;
        if (if1.cnt_clr) cq1 <= 4'd0;
        else if (if1.en) cq1 <= if1.up ? cq1 + 4'd1 : cq1 - 4'd1;
        if (if2.cnt_clr) cq2 <= 4'd0;
        else if (if2.en) cq2 <= if2.up ? cq2 + 4'd1 : cq2 - 4'd1;
    end

    typedef struct packed {
        logic       busy;
        logic       cnt_clr;
        logic       en;
        logic       up;
        logic       done;
        logic       err;
        logic [3:0] pc;
        logic       qchk;
        logic [3:0] q;
    } rec_t;

    rec_t exp_q [3][$];
    int   checks = 0;
    int   errors = 0;

    function automatic rec_t pack(logic b, logic c, logic e, logic u, logic d,
                                  logic er, logic [3:0] pc, logic [3:0] q);
        rec_t r;
        r = {b, c, e, u, d, er, pc, 1'b1, q};
        return r;
    endfunction

    task automatic push(int idx, logic b, logic c, logic e, logic u, logic d,
                        logic er, logic [3:0] pc, logic qc, logic [3:0] q);
        rec_t r;
        r = {b, c, e, u, d, er, pc, qc, q};
        exp_q[idx].push_back(r);
    endtask

    // n busy cycles with given controls; q advances by step each cycle.
    task automatic seg(int idx, int n, logic e, logic u, logic d,
                       logic [3:0] pc, logic [3:0] q, int step);
        for (int k = 0; k < n; k++)
            push(idx, 1'b1, 1'b0, e, u, d, 1'b0, pc, 1'b1, 4'(int'(q) + step * k));
    endtask

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        rec_t o;
        rec_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: o = pack(if0.busy, if0.cnt_clr, if0.en, if0.up, if0.done, if0.err, if0.pass_cnt, if0.q);
                1: o = pack(if1.busy, if1.cnt_clr, if1.en, if1.up, if1.done, if1.err, if1.pass_cnt, if1.q);
                default: o = pack(if2.busy, if2.cnt_clr, if2.en, if2.up, if2.done, if2.err, if2.pass_cnt, if2.q);
            endcase
            if (o.busy || o.done || o.err || o.en || o.cnt_clr) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL dut%0d unexpected_output: got busy=%b clr=%b en=%b up=%b done=%b err=%b pc=%0d q=%0d, required no activity",
                             i, o.busy, o.cnt_clr, o.en, o.up, o.done, o.err, o.pc, o.q);
                end else begin
                    e = exp_q[i].pop_front();
                    if ({o.busy, o.cnt_clr, o.en, o.up, o.done, o.err, o.pc} !=
                        {e.busy, e.cnt_clr, e.en, e.up, e.done, e.err, e.pc} ||
                        (e.qchk && (o.q != e.q))) begin
                        errors++;
                        $display("FAIL dut%0d cycle_outputs: got busy=%b clr=%b en=%b up=%b done=%b err=%b pc=%0d q=%0d, required busy=%b clr=%b en=%b up=%b done=%b err=%b pc=%0d q=%0d",
                                 i, o.busy, o.cnt_clr, o.en, o.up, o.done, o.err, o.pc, o.q,
                                 e.busy, e.cnt_clr, e.en, e.up, e.done, e.err, e.pc, e.q);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        if0.start = 1'b0; if0.stop = 1'b0; if0.lo = 4'd0; if0.hi = 4'd1;
        if1.start = 1'b0; if1.stop = 1'b0; if1.lo = 4'd0; if1.hi = 4'd1;
        if2.start = 1'b0; if2.stop = 1'b0; if2.lo = 4'd0; if2.hi = 4'd1;

        // Reset values.
        tick(2);
        check("rst_up",       int'(if1.up), 1);
        check("rst_en",       int'(if1.en), 0);
        check("rst_cnt_clr",  int'(if1.cnt_clr), 0);
        check("rst_busy",     int'(if1.busy), 0);
        check("rst_done",     int'(if1.done), 0);
        check("rst_err",      int'(if1.err), 0);
        check("rst_pass_cnt", int'(if1.pass_cnt), 0);
        clr = 1'b1;
        tick(2);

        // lo=2 hi=5 DWELL=2 PASSES=1.
        if0.lo = 4'd2; if0.hi = 4'd5;
        push(0, 1, 1, 0, 1, 0, 0, 4'd0, 1'b0, 4'd0);
        seg(0, 2, 1, 1, 0, 4'd0, 4'd0,  1);
        seg(0, 3, 1, 1, 0, 4'd0, 4'd2,  1);
        seg(0, 2, 0, 0, 0, 4'd0, 4'd5,  0);
        seg(0, 3, 1, 0, 0, 4'd0, 4'd5, -1);
        seg(0, 2, 0, 1, 0, 4'd0, 4'd2,  0);
        seg(0, 1, 0, 1, 1, 4'd1, 4'd2,  0);
        if0.start = 1'b1; tick(1); if0.start = 1'b0;
        tick(20);
        check("t1_drain",    exp_q[0].size(), 0);
        check("t1_busy",     int'(if0.busy), 0);
        check("t1_pass_cnt", int'(if0.pass_cnt), 1);

        // lo=0 hi=1 DWELL=3 PASSES=2, with a start pulse while busy.
        push(1, 1, 1, 0, 1, 0, 0, 4'd0, 1'b0, 4'd0);
        for (int p = 0; p < 2; p++) begin
            seg(1, 1, 1, 1, 0, 4'(p), 4'd0,  1);
            seg(1, 3, 0, 0, 0, 4'(p), 4'd1,  0);
            seg(1, 1, 1, 0, 0, 4'(p), 4'd1, -1);
            seg(1, 3, 0, 1, 0, 4'(p), 4'd0,  0);
        end
        seg(1, 1, 0, 1, 1, 4'd2, 4'd0, 0);
        if1.start = 1'b1; tick(1); if1.start = 1'b0;
        tick(2);
        if1.start = 1'b1; tick(1); if1.start = 1'b0;
        tick(25);
        check("t2_drain",    exp_q[1].size(), 0);
        check("t2_busy",     int'(if1.busy), 0);
        check("t2_pass_cnt", int'(if1.pass_cnt), 2);

        // Rejected starts: lo==hi, then lo>hi.
        if1.lo = 4'd7; if1.hi = 4'd7;
        push(1, 0, 0, 0, 1, 0, 1, 4'd2, 1'b1, 4'd0);
        if1.start = 1'b1; tick(1); if1.start = 1'b0;
        tick(3);
        check("t3a_drain", exp_q[1].size(), 0);
        if1.lo = 4'd9; if1.hi = 4'd3;
        push(1, 0, 0, 0, 1, 0, 1, 4'd2, 1'b1, 4'd0);
        if1.start = 1'b1; tick(1); if1.start = 1'b0;
        tick(3);
        check("t3b_drain", exp_q[1].size(), 0);
        check("t3_busy",   int'(if1.busy), 0);

        // lo=1 hi=6, start together with stop, then stop in FALL at q=4.
        if1.lo = 4'd1; if1.hi = 4'd6;
        push(1, 1, 1, 0, 1, 0, 0, 4'd0, 1'b0, 4'd0);
        seg(1, 1, 1, 1, 0, 4'd0, 4'd0,  1);
        seg(1, 5, 1, 1, 0, 4'd0, 4'd1,  1);
        seg(1, 3, 0, 0, 0, 4'd0, 4'd6,  0);
        seg(1, 3, 1, 0, 0, 4'd0, 4'd6, -1);
        if1.start = 1'b1; if1.stop = 1'b1; tick(1);
        if1.start = 1'b0; if1.stop = 1'b0;
        tick(12);
        if1.stop = 1'b1; tick(1); if1.stop = 1'b0;
        check("t4_busy",     int'(if1.busy), 0);
        check("t4_en",       int'(if1.en), 0);
        check("t4_done",     int'(if1.done), 0);
        check("t4_q_hold",   int'(cq1), 3);
        check("t4_pass_cnt", int'(if1.pass_cnt), 0);
        tick(4);
        check("t4_drain",    exp_q[1].size(), 0);

        // Fresh start (lo=1 hi=2), async clear mid-RISE of the second trip.
        if1.lo = 4'd1; if1.hi = 4'd2;
        push(1, 1, 1, 0, 1, 0, 0, 4'd0, 1'b1, 4'd3);
        seg(1, 1, 1, 1, 0, 4'd0, 4'd0,  1);
        seg(1, 1, 1, 1, 0, 4'd0, 4'd1,  1);
        seg(1, 3, 0, 0, 0, 4'd0, 4'd2,  0);
        seg(1, 1, 1, 0, 0, 4'd0, 4'd2, -1);
        seg(1, 3, 0, 1, 0, 4'd0, 4'd1,  0);
        seg(1, 1, 1, 1, 0, 4'd1, 4'd1,  1);
        if1.start = 1'b1; tick(1); if1.start = 1'b0;
        tick(10);
        #6;
        clr = 1'b0;
        #1;
        check("t5_up",       int'(if1.up), 1);
        check("t5_en",       int'(if1.en), 0);
        check("t5_cnt_clr",  int'(if1.cnt_clr), 0);
        check("t5_busy",     int'(if1.busy), 0);
        check("t5_done",     int'(if1.done), 0);
        check("t5_err",      int'(if1.err), 0);
        check("t5_pass_cnt", int'(if1.pass_cnt), 0);
        #1;
        clr = 1'b1;
        tick(2);
        check("t5_idle_after", int'(if1.busy), 0);
        check("t5_drain",      exp_q[1].size(), 0);

        // PASSES=0 lo=0 hi=1 DWELL=1, 17 round trips then stop.
        push(2, 1, 1, 0, 1, 0, 0, 4'd0, 1'b0, 4'd0);
        for (int k = 0; k < 17; k++) begin
            seg(2, 1, 1, 1, 0, 4'(k % 16), 4'd0,  1);
            seg(2, 1, 0, 0, 0, 4'(k % 16), 4'd1,  0);
            seg(2, 1, 1, 0, 0, 4'(k % 16), 4'd1, -1);
            seg(2, 1, 0, 1, 0, 4'(k % 16), 4'd0,  0);
        end
        seg(2, 1, 1, 1, 0, 4'd1, 4'd0, 1);
        if2.start = 1'b1; tick(1); if2.start = 1'b0;
        tick(69);
        if2.stop = 1'b1; tick(1); if2.stop = 1'b0;
        check("t6_busy",     int'(if2.busy), 0);
        check("t6_pass_cnt", int'(if2.pass_cnt), 1);
        tick(3);
        check("t6_drain",    exp_q[2].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
